// File: rtl/uart_rx.sv
// UART receiver: oversampled serial line in, MSB-first parallel word out.
// The start bit is validated at mid-bit, and a bad stop bit raises a one-cycle framing-error strobe.
module uart_rx #(
   parameter int RXD_BIT_NUM = 8,
   parameter int OVERSAMPLE  = 16,
   parameter bit START_BIT   = 1'b0,
   parameter bit STOP_BIT    = 1'b1
) (
   input  logic                   uart_clk_tx,
   input  logic                   RST_n,
   input  logic                   uart_rx_data,
   output logic [RXD_BIT_NUM-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   rx_frame_err,
   output logic                   rx_busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(RXD_BIT_NUM + 1);
   localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(RXD_BIT_NUM - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t                 state, next_state;
   logic                   sync0, rxs;
   logic [SW-1:0]          sample_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [RXD_BIT_NUM-1:0] shreg;
   logic                   data_sample, valid_set, err_set;

   // The flops come out of reset at the idle level, so a reset never looks like a start edge.
   always_ff @(posedge uart_clk_tx) begin
      if (!RST_n) begin
         sync0 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync0 <= uart_rx_data;
         rxs   <= sync0;
      end
   end

   always_ff @(posedge uart_clk_tx) begin
      if (!RST_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (rxs == START_BIT) next_state = START;
         START:     if (sample_cnt == MID_CNT)
                       next_state = (rxs == START_BIT) ? DATA : IDLE;
         DATA:      if (sample_cnt == LAST_CNT && bit_cnt == LAST_BIT) next_state = STOP;
         STOP:      if (sample_cnt == LAST_CNT)
                       next_state = (rxs == STOP_BIT) ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rxs == 1'b1) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      data_sample = 1'b0;
      valid_set   = 1'b0;
      err_set     = 1'b0;
      if (state == DATA && sample_cnt == LAST_CNT)
         data_sample = 1'b1;
      if (state == STOP && sample_cnt == LAST_CNT) begin
         valid_set = (rxs == STOP_BIT);
         err_set   = (rxs != STOP_BIT);
      end
   end

   // The sample counter restarts on every state change, so each phase counts from its own entry edge.
   always_ff @(posedge uart_clk_tx) begin
      if (!RST_n) begin
         sample_cnt   <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         rx_valid     <= valid_set;
         rx_frame_err <= err_set;
         rx_busy      <= (next_state != IDLE);
         if (valid_set)
            rx_data <= shreg;
         if (next_state != state || state == IDLE || state == WAIT_IDLE || sample_cnt == LAST_CNT)
            sample_cnt <= '0;
         else
            sample_cnt <= sample_cnt + 1'b1;
         if (state != DATA)
            bit_cnt <= '0;
         else if (data_sample)
            bit_cnt <= bit_cnt + 1'b1;
         if (data_sample)
            shreg <= {shreg[RXD_BIT_NUM-2:0], rxs};
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are built from per-cycle bit positions,
// and every expected strobe is queued and matched as the receiver reports it.
module tb_uart_rx;

   localparam int OS = 16;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          RST_n;
   logic          line;
   logic [NB-1:0] rx_data;
   logic          rx_valid, rx_frame_err, rx_busy;

   typedef struct {
      bit            is_err;
      logic [NB-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [NB-1:0] model_data = '0;
   int            cyc = 0;
   int            tests = 0;
   int            errors = 0;

   uart_rx #(.RXD_BIT_NUM(NB), .OVERSAMPLE(OS), .START_BIT(1'b0), .STOP_BIT(1'b1)) dut (
      .uart_clk_tx (clk),
      .RST_n       (RST_n),
      .uart_rx_data(line),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bit time is num/den cycles; each cycle's level comes from its position in the frame.
   task automatic apply_stimulus(input logic [NB-1:0] data, input int num, input int den,
                                 input logic stop_lvl, input int abort_at);
      int   len, fall, b;
      logic lvl, aborted;
      fall    = cyc;
      len     = ((NB + 2) * num + den - 1) / den;
      aborted = 1'b0;
      if (abort_at < 0) begin
         if (stop_lvl) begin
            sb.push_back('{1'b0, data, (den == 1) ? fall + 3 + OS / 2 + (NB + 1) * OS : -1});
            model_data = data;
         end else begin
            sb.push_back('{1'b1, model_data, (den == 1) ? fall + 3 + OS / 2 + (NB + 1) * OS : -1});
         end
      end
      for (int i = 0; i < len; i++) begin
         b = i * den / num;
         if (b == 0)       lvl = 1'b0;
         else if (b <= NB) lvl = data[NB - b];
         else              lvl = stop_lvl;
         if (i == abort_at) RST_n = 1'b0;
         if (abort_at >= 0 && i == abort_at + 1) begin
            check_output("reset rx_data", rx_data, 0);
            check_output("reset rx_valid", rx_valid, 0);
            check_output("reset rx_frame_err", rx_frame_err, 0);
            check_output("reset rx_busy", rx_busy, 0);
            RST_n      = 1'b1;
            aborted    = 1'b1;
            model_data = '0;
         end
         if (i == 40 && !aborted) check_output("busy mid-frame", rx_busy, 1);
         line = aborted ? 1'b1 : lvl;
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (RST_n && (rx_valid || rx_frame_err)) begin
         if (sb.size() == 0) begin
            tests++;
            errors++;
            $display("[TB] FAIL unexpected strobe: valid=%0b err=%0b, required none (cycle %0d)",
                     rx_valid, rx_frame_err, cyc);
         end else begin
            mon_e = sb.pop_front();
            check_output("strobe valid", rx_valid, !mon_e.is_err);
            check_output("strobe frame_err", rx_frame_err, mon_e.is_err);
            check_output("strobe rx_data", rx_data, mon_e.data);
            if (mon_e.cyc >= 0) check_output("strobe cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gap;
      logic st;
      RST_n = 1'b0;
      line  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("init rx_data", rx_data, 0);
      check_output("init rx_valid", rx_valid, 0);
      check_output("init rx_frame_err", rx_frame_err, 0);
      check_output("init rx_busy", rx_busy, 0);
      RST_n = 1'b1;
      idle(5);

      apply_stimulus(8'hA5, 16, 1, 1'b1, -1);
      idle(10);

      line = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      line = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check_output("glitch busy rises", rx_busy, 1);
      idle(12);
      check_output("glitch busy drops", rx_busy, 0);
      check_output("glitch rx_data kept", rx_data, model_data);

      apply_stimulus(8'h3C, 16, 1, 1'b0, -1);
      line = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      check_output("break busy held", rx_busy, 1);
      idle(6);
      check_output("break busy released", rx_busy, 0);

      apply_stimulus(8'h00, 16, 1, 1'b1, -1);
      apply_stimulus(8'hFF, 16, 1, 1'b1, -1);
      idle(10);

      apply_stimulus(8'hC3, 16, 1, 1'b1, 85);
      idle(20);
      check_output("post-abort rx_data", rx_data, 0);
      apply_stimulus(8'h5A, 16, 1, 1'b1, -1);
      idle(10);

      apply_stimulus(8'h96, 31, 2, 1'b1, -1);
      idle(20);
      apply_stimulus(8'h96, 33, 2, 1'b1, -1);
      idle(20);

      for (int k = 0; k < 12; k++) begin
         st = ($urandom_range(7) != 0);
         apply_stimulus(NB'($urandom), 16, 1, st, -1);
         gap = st ? $urandom_range(12) : 6 + $urandom_range(6);
         idle(gap);
      end

      for (int w = 0; w < 400 && sb.size() != 0; w++) @(posedge clk);
      check_output("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
